// File: rtl/collatz_check.sv
// collatz_check: follows a stream of Collatz sequence values and checks that
// every sample is the correct successor of the previously accepted one.
// It counts verified transitions, tracks the peak value, reports arrival at 1
// (done) and latches any mismatch, overflow or illegal start (err) until reset.
module collatz_check #(
  parameter int O = 14,  // width of an observed sequence value
  parameter int C = 8    // width of the transition counter
) (
  input  logic         clk,
  input  logic         arst,      // synchronous, active-high
  input  logic         en,        // sample strobe
  input  logic [O-1:0] in,        // observed sequence value
  output logic [C-1:0] steps,     // verified transitions, saturating
  output logic [O-1:0] peak,      // largest accepted value
  output logic [O-1:0] expected,  // next value the checker will accept
  output logic         done,      // sequence reached 1 cleanly
  output logic         err        // sticky error flag
);

  typedef enum logic [1:0] {
    IDLE,   // waiting for the first value of a sequence
    TRACK,  // following the sequence, value > 1
    DONE,   // reached 1; only repeated 1s are legal
    ERROR   // absorbing until reset
  } state_t;

  localparam logic [O-1:0] VALUE_ONE = {{(O-1){1'b0}}, 1'b1};
  localparam logic [O+1:0] WIDE_ONE  = {{(O+1){1'b0}}, 1'b1};
  localparam logic [C-1:0] STEPS_MAX = '1;
  localparam logic [C-1:0] STEPS_ONE = {{(C-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [O-1:0] prev_q,  prev_d;
  logic [C-1:0] steps_q, steps_d;
  logic [O-1:0] peak_q,  peak_d;
  logic         done_q,  err_q;

  // Successor of prev, computed two bits wider so that 3*prev+1 never wraps.
  logic [O+1:0] prev_wide;
  logic [O+1:0] next_wide;
  logic         overflow;
  logic [O-1:0] next_value;

  // Collatz successor of the last accepted value and its overflow flag.
  always_comb begin
    prev_wide = {2'b00, prev_q};
    if (prev_q[0]) begin
      next_wide = (prev_wide << 1) + prev_wide + WIDE_ONE;
    end else begin
      next_wide = prev_wide >> 1;
    end
    overflow   = |next_wide[O+1:O];
    next_value = next_wide[O-1:0];
  end

  // Next-state and datapath update decision for the current sample.
  always_comb begin
    // NOTE: every signal written here gets its hold value first; a path that
    // left one unassigned would infer a latch instead of combinational logic.
    state_d = state_q;
    prev_d  = prev_q;
    steps_d = steps_q;
    peak_d  = peak_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (in == '0) begin
            state_d = ERROR;
          end else begin
            prev_d  = in;
            peak_d  = in;
            state_d = (in == VALUE_ONE) ? DONE : TRACK;
          end
        end

        TRACK: begin
          if (overflow) begin
            // The true successor does not fit; no sample can be trusted.
            state_d = ERROR;
          end else if (in == next_value) begin
            prev_d  = in;
            peak_d  = (in > peak_q) ? in : peak_q;
            steps_d = (steps_q == STEPS_MAX) ? steps_q : steps_q + STEPS_ONE;
            state_d = (in == VALUE_ONE) ? DONE : TRACK;
          end else begin
            state_d = ERROR;
          end
        end

        DONE: begin
          // The generator holds at 1 once finished; anything else is a fault.
          if (in != VALUE_ONE) begin
            state_d = ERROR;
          end
        end

        ERROR: begin
          state_d = ERROR;
        end

        default: begin
          state_d = ERROR;
        end
      endcase
    end
  end

  // State and datapath registers; reset wins over a simultaneous sample.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (arst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      steps_q <= '0;
      peak_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      steps_q <= steps_d;
      peak_q  <= peak_d;
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERROR);
    end
  end

  assign steps    = steps_q;
  assign peak     = peak_q;
  assign expected = next_value;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_collatz_check.sv
// tb_collatz_check: scoreboard bench for collatz_check. Three instances cover
// the default widths, a 4-bit value width and a 2-bit step counter; all share
// one stimulus bus and only the instance under test is compared.
module tb_collatz_check;

  typedef struct packed {
    logic [15:0] steps;
    logic [15:0] peak;
    logic [15:0] expv;
    logic        done;
    logic        err;
  } exp_t;

  localparam int ST_IDLE  = 0;
  localparam int ST_TRACK = 1;
  localparam int ST_DONE  = 2;
  localparam int ST_ERR   = 3;

  logic        clk  = 1'b0;
  logic        arst = 1'b1;
  logic        en   = 1'b0;
  logic [13:0] din  = '0;

  logic [7:0]  s0_steps;
  logic [13:0] s0_peak, s0_expected;
  logic        s0_done, s0_err;
  logic [7:0]  s1_steps;
  logic [3:0]  s1_peak, s1_expected;
  logic        s1_done, s1_err;
  logic [1:0]  s2_steps;
  logic [13:0] s2_peak, s2_expected;
  logic        s2_done, s2_err;

  int n_checks = 0;
  int n_fail   = 0;
  int sel = 0;   // instance under test
  int mo  = 14;  // its value width
  int mc  = 8;   // its counter width

  int m_st, m_prev, m_steps, m_peak;
  exp_t sb[$];

  collatz_check #(.O(14), .C(8)) u_main (
    .clk(clk), .arst(arst), .en(en), .in(din),
    .steps(s0_steps), .peak(s0_peak), .expected(s0_expected),
    .done(s0_done), .err(s0_err)
  );

  collatz_check #(.O(4), .C(8)) u_o4 (
    .clk(clk), .arst(arst), .en(en), .in(din[3:0]),
    .steps(s1_steps), .peak(s1_peak), .expected(s1_expected),
    .done(s1_done), .err(s1_err)
  );

  collatz_check #(.O(14), .C(2)) u_c2 (
    .clk(clk), .arst(arst), .en(en), .in(din),
    .steps(s2_steps), .peak(s2_peak), .expected(s2_expected),
    .done(s2_done), .err(s2_err)
  );

  always #5 clk = ~clk;

  // Reference model, plain integer arithmetic.
  function automatic int m_next();
    return (m_prev % 2 == 1) ? 3 * m_prev + 1 : m_prev / 2;
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE; m_prev = 0; m_steps = 0; m_peak = 0;
  endtask

  task automatic model_sample(input int v);
    int nx;
    nx = m_next();
    case (m_st)
      ST_IDLE: begin
        if (v == 0) m_st = ST_ERR;
        else begin
          m_prev = v; m_peak = v;
          m_st = (v == 1) ? ST_DONE : ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (nx >= (1 << mo)) m_st = ST_ERR;
        else if (v == nx) begin
          m_prev = v;
          if (v > m_peak) m_peak = v;
          if (m_steps < (1 << mc) - 1) m_steps = m_steps + 1;
          m_st = (v == 1) ? ST_DONE : ST_TRACK;
        end else m_st = ST_ERR;
      end
      ST_DONE: if (v != 1) m_st = ST_ERR;
      default: m_st = ST_ERR;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t o;
    o.steps = 16'(m_steps);
    o.peak  = 16'(m_peak);
    o.expv  = 16'(m_next() % (1 << mo));
    o.done  = (m_st == ST_DONE);
    o.err   = (m_st == ST_ERR);
    return o;
  endfunction

  function automatic exp_t sample_dut();
    exp_t o;
    case (sel)
      1: begin
        o.steps = 16'(s1_steps); o.peak = 16'(s1_peak); o.expv = 16'(s1_expected);
        o.done = s1_done; o.err = s1_err;
      end
      2: begin
        o.steps = 16'(s2_steps); o.peak = 16'(s2_peak); o.expv = 16'(s2_expected);
        o.done = s2_done; o.err = s2_err;
      end
      default: begin
        o.steps = 16'(s0_steps); o.peak = 16'(s0_peak); o.expv = 16'(s0_expected);
        o.done = s0_done; o.err = s0_err;
      end
    endcase
    return o;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("steps=%0d peak=%0d expected=%0d done=%0b err=%0b",
                     e.steps, e.peak, e.expv, e.done, e.err);
  endfunction

  // Drive one cycle, push the model's prediction, sample 1 time unit after the edge.
  task automatic drive(input bit r, input bit e, input int v);
    arst = r; en = e; din = v[13:0];
    if (r) model_reset();
    else if (e) model_sample(v);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    arst = 1'b0; en = 1'b0;
  endtask

  task automatic select(input int s, input int o, input int c);
    exp_t dummy;
    sel = s; mo = o; mc = c;
    drive(1'b1, 1'b0, 0);
    dummy = sb.pop_front();
  endtask

  task automatic test_reset();
    exp_t obs, want;
    sel = 0; mo = 14; mc = 8;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 0);
      obs = sample_dut(); want = sb.pop_front(); n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL reset[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end
    n_checks++;
    if (obs.steps !== 16'd0 || obs.peak !== 16'd0 || obs.done !== 1'b0 || obs.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_values got %s want all zero", fmt(obs));
    end
  endtask

  task automatic test_seq_six();
    exp_t obs, want;
    int vals[$] = '{6, 3, 10, 5, 16, 8, 4, 2, 1};
    select(0, 14, 8);
    foreach (vals[i]) begin
      drive(1'b0, 1'b1, vals[i]);
      obs = sample_dut(); want = sb.pop_front(); n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL seq6[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end
    n_checks++;
    if (obs.steps !== 16'd8 || obs.peak !== 16'd16 || obs.done !== 1'b1 || obs.err !== 1'b0) begin
      n_fail++; $display("FAIL seq6_final got %s want steps=8 peak=16 done=1 err=0", fmt(obs));
    end
  endtask

  task automatic test_seq_seven();
    exp_t obs, want;
    int vals[$] = '{7, 22, 11, 34, 17, 52, 26, 13, 40, 20, 10, 5, 16, 8, 4, 2, 1, 1, 1, 1};
    select(0, 14, 8);
    foreach (vals[i]) begin
      drive(1'b0, 1'b1, vals[i]);
      obs = sample_dut(); want = sb.pop_front(); n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL seq7[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
      if (i >= 16) begin
        n_checks++;
        if (obs.steps !== 16'd16 || obs.peak !== 16'd52 || obs.done !== 1'b1 || obs.err !== 1'b0) begin
          n_fail++; $display("FAIL seq7_hold[%0d] got %s want steps=16 peak=52 done=1 err=0", i, fmt(obs));
        end
      end
    end
  endtask

  task automatic test_mismatch();
    exp_t obs, want;
    int vals[$] = '{6, 3, 11, 1};
    select(0, 14, 8);
    foreach (vals[i]) begin
      drive(1'b0, 1'b1, vals[i]);
      obs = sample_dut(); want = sb.pop_front(); n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL mismatch[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
      if (i >= 2) begin
        n_checks++;
        if (obs.err !== 1'b1 || obs.done !== 1'b0 || obs.steps !== 16'd1 || obs.peak !== 16'd6) begin
          n_fail++; $display("FAIL mismatch_err[%0d] got %s want steps=1 peak=6 done=0 err=1", i, fmt(obs));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t obs, want;
    int vals[$] = '{6, 3, 10, -1, 4, 2, 1};  // -1 marks reset with en=1, in=5
    select(0, 14, 8);
    foreach (vals[i]) begin
      if (vals[i] < 0) drive(1'b1, 1'b1, 5);
      else drive(1'b0, 1'b1, vals[i]);
      obs = sample_dut(); want = sb.pop_front(); n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL reset_mid[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
      if (vals[i] < 0) begin
        n_checks++;
        if (obs.steps !== 16'd0 || obs.peak !== 16'd0 || obs.done !== 1'b0 || obs.err !== 1'b0) begin
          n_fail++; $display("FAIL reset_mid_clear got %s want all zero", fmt(obs));
        end
      end
    end
    n_checks++;
    if (obs.steps !== 16'd2 || obs.done !== 1'b1 || obs.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_final got %s want steps=2 done=1 err=0", fmt(obs));
    end
  endtask

  task automatic test_gap();
    exp_t obs, want;
    select(0, 14, 8);
    for (int i = 0; i < 9; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 6);
      else if (i == 1) drive(1'b0, 1'b1, 3);
      else if (i < 7) drive(1'b0, 1'b0, int'($urandom_range(0, 16383)));
      else drive(1'b0, 1'b1, (i == 7) ? 10 : 5);
      obs = sample_dut(); want = sb.pop_front(); n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL gap[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
      if (i >= 2 && i < 7) begin
        n_checks++;
        if (obs.steps !== 16'd1 || obs.peak !== 16'd6 || obs.expv !== 16'd10) begin
          n_fail++; $display("FAIL gap_hold[%0d] got %s want steps=1 peak=6 expected=10", i, fmt(obs));
        end
      end
    end
  endtask

  task automatic test_overflow();
    exp_t obs, want;
    select(1, 4, 8);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(1'b1, 1'b0, 0);
      else drive(1'b0, 1'b1, (i == 0) ? 15 : (i == 1) ? 14 : 0);
      obs = sample_dut(); want = sb.pop_front(); n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL overflow[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
      if (i == 1 || i >= 3) begin
        n_checks++;
        if (obs.err !== 1'b1 || obs.done !== 1'b0) begin
          n_fail++; $display("FAIL overflow_err[%0d] got %s want err=1 done=0", i, fmt(obs));
        end
      end
    end
  endtask

  task automatic test_saturate();
    exp_t obs, want;
    int vals[$] = '{6, 3, 10, 5, 16, 8};
    select(2, 14, 2);
    foreach (vals[i]) begin
      drive(1'b0, 1'b1, vals[i]);
      obs = sample_dut(); want = sb.pop_front(); n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL saturate[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end
    n_checks++;
    if (obs.steps !== 16'd3 || obs.peak !== 16'd16 || obs.err !== 1'b0) begin
      n_fail++; $display("FAIL saturate_final got %s want steps=3 peak=16 err=0", fmt(obs));
    end
  endtask

  task automatic test_error_absorb();
    exp_t obs, want;
    int vals[$] = '{2, 1, 4, 1, 2, 0};
    select(0, 14, 8);
    foreach (vals[i]) begin
      drive(1'b0, (i != 4), vals[i]);
      obs = sample_dut(); want = sb.pop_front(); n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL absorb[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
      if (i >= 2) begin
        n_checks++;
        if (obs.err !== 1'b1 || obs.done !== 1'b0 || obs.steps !== 16'd1 || obs.peak !== 16'd2) begin
          n_fail++; $display("FAIL absorb_err[%0d] got %s want steps=1 peak=2 done=0 err=1", i, fmt(obs));
        end
      end
    end
    select(0, 14, 8);
    drive(1'b0, 1'b1, 0);
    obs = sample_dut(); want = sb.pop_front(); n_checks++;
    if (obs !== want || obs.err !== 1'b1) begin
      n_fail++; $display("FAIL zero_start got %s want %s", fmt(obs), fmt(want));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_seq_six();
    test_seq_seven();
    test_mismatch();
    test_reset_mid();
    test_gap();
    test_overflow();
    test_saturate();
    test_error_absorb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/collatz_check.md
COLLATZ_CHECK -- requirements
Module: collatz_check

Interface
REQ-001 Parameter O, default 14: width in bits of the observed sequence value.
REQ-002 Parameter C, default 8: width in bits of the step counter.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 arst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
REQ-005 en  input  1  sample strobe; `in` is consumed only on an edge where en=1.
REQ-006 in  input  O  observed Collatz sequence value, i.e. the stream emitted by the collatz generator.
REQ-007 steps  output  C  number of verified sequence transitions.
REQ-008 peak  output  O  largest value accepted so far.
REQ-009 expected  output  O  next value the checker will accept (low O bits).
REQ-010 done  output  1  high when the sequence has reached 1 with no error.
REQ-011 err  output  1  high when a mismatch, overflow or illegal start has been detected; sticky.

Function
REQ-012 The block SHALL hold a registered copy of the last accepted value, `prev`, O bits wide.
REQ-013 The FSM states SHALL be IDLE, TRACK, DONE and ERROR.
REQ-014 The next-value computation SHALL be: if prev is odd, 3*prev+1 computed in O+2 bits; if prev is even, prev>>1.
REQ-015 The block SHALL flag overflow when any of the upper 2 bits of the O+2-bit result is nonzero.
REQ-016 The `expected` output SHALL be the low O bits of the next-value result.
REQ-017 IDLE, en=1, in=0: go to ERROR, set err.
REQ-018 IDLE, en=1, in=1: load prev=1 and peak=1, keep steps=0, go to DONE.
REQ-019 IDLE, en=1, in>1: load prev=in and peak=in, keep steps=0, go to TRACK.
REQ-020 TRACK, en=1, overflow set: go to ERROR regardless of `in`.
REQ-021 TRACK, en=1, in==expected:
- set prev=in;
- set peak=max(peak,in);
- increment steps, saturating at 2^C-1 (no wrap);
- go to DONE if in==1, otherwise stay in TRACK.
REQ-022 TRACK, en=1, in!=expected: go to ERROR; prev, steps and peak SHALL hold their values.
REQ-023 DONE, en=1, in==1: hold all state; this accepts the generator's hold-at-1 behaviour.
REQ-024 DONE, en=1, in!=1: go to ERROR; steps and peak hold.
REQ-025 ERROR SHALL be absorbing until reset, ignoring en and in.
REQ-026 When en=0, the block SHALL hold all state and outputs.
REQ-027 Outputs SHALL be registered; the effect of a sample SHALL be visible one cycle after the accepting edge.
REQ-028 done SHALL be 1 exactly in DONE; err SHALL be 1 exactly in ERROR.

Reset
REQ-029 On an edge with arst=1, the block SHALL load: state=IDLE, prev=0, steps=0, peak=0, done=0, err=0.
REQ-030 arst SHALL take priority over a simultaneous en=1; that sample SHALL be discarded.
REQ-031 arst asserted mid-sequence or in DONE/ERROR SHALL return the block to IDLE on the next edge, with no residual state.

Verification
REQ-032 Feed 6,3,10,5,16,8,4,2,1, one per en pulse -> steps=8, peak=16, done=1, err=0.
REQ-033 Feed 7,22,11,34,17,52,26,13,40,20,10,5,16,8,4,2,1 -> steps=16, peak=52, done=1; then 3 more samples of 1 -> no change.
REQ-034 Feed 6,3,11 -> err=1 after the third sample, steps=1, peak=6; then feed 1 -> still err=1, done=0.
REQ-035 Feed 6,3,10, then assert arst for 1 cycle with en=1 and in=5 -> steps=0, peak=0, done=0, err=0, state IDLE; then feed 4,2,1 -> steps=2, done=1.
REQ-036 With O=4: feed 15, then any value -> err=1 (46 overflows). First sample 0 -> err=1.
REQ-037 With C=2: feed 6,3,10,5,16 -> steps saturates at 3.
REQ-038 Gap test: hold en=0 for 5 cycles between samples -> steps, peak and expected unchanged during the gap.
